// File: rtl/tetris_pkg.sv
// Shared types and scoring constants for the line-clear score accumulator.
package tetris_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned PTS_SINGLE = 40;
  localparam int unsigned PTS_DOUBLE = 100;
  localparam int unsigned PTS_TRIPLE = 300;
  localparam int unsigned PTS_TETRIS = 1200;

  // 1200 needs 11 bits; every base value fits here.
  localparam int BASE_W = 11;
  // Iteration counter must hold level+1 = 16.
  localparam int CNT_W  = 5;

  // Base points for a given number of cleared rows; meaningless counts score nothing.
  function automatic logic [BASE_W-1:0] base_points(input logic [2:0] lines);
    logic [BASE_W-1:0] pts;
    case (lines)
      3'd1:    pts = BASE_W'(PTS_SINGLE);
      3'd2:    pts = BASE_W'(PTS_DOUBLE);
      3'd3:    pts = BASE_W'(PTS_TRIPLE);
      3'd4:    pts = BASE_W'(PTS_TETRIS);
      default: pts = '0;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/score_accumulator_adder.sv
// Plain ripple-style adder used for the score path; overflow is read from the
// top bit of the caller's widened operands.
module score_accumulator_adder #(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  // Single combinational add with carry-in.
  always_comb begin
    sum = a + b + W'(cin);
  end

endmodule

// File: rtl/score_accumulator.sv
// Line-clear score accumulator: multiplies base points by (level+1) through
// repeated addition, saturating at the maximum representable score.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for an event; in_ready=1
//   ADD     | adding the captured base once per cycle, level+1 times
//   DONE    | one-cycle done pulse, then back to IDLE
module score_accumulator
  import tetris_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       lines,
  input  logic [3:0]       level,
  output logic [WIDTH-1:0] score,
  output logic             done,
  output logic             saturated
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [WIDTH-1:0]    score_q, score_d;
  logic                sat_q, sat_d;

  logic [WIDTH:0]      add_a;
  logic [WIDTH:0]      add_b;
  logic [WIDTH:0]      add_sum;
  logic [BASE_W-1:0]   in_base;

  assign add_a   = {1'b0, score_q};
  assign add_b   = {{(WIDTH + 1 - BASE_W){1'b0}}, base_q};
  assign in_base = base_points(lines);

  score_accumulator_adder #(
    .W (WIDTH + 1)
  ) u_adder (
    .a   (add_a),
    .b   (add_b),
    .cin (1'b0),
    .sum (add_sum)
  );

  // Next-state, counter, score and saturation logic; clear overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    score_d = score_q;
    sat_d   = sat_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          base_d = in_base;
          // A saturated score cannot move, so skip the add phase entirely.
          if (sat_q || (in_base == '0)) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = CNT_W'({1'b0, level}) + CNT_W'(1);
            state_d = ST_ADD;
          end
        end
      end
      ST_ADD: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (add_sum[WIDTH]) begin
          score_d = '1;
          sat_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          score_d = add_sum[WIDTH-1:0];
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      base_d  = '0;
      score_d = '0;
      sat_d   = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset taking top priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      score_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      score_q <= score_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign score     = score_q;
  assign saturated = sat_q;

endmodule

// File: tb/tb_score_accumulator.sv
// Self-checking bench for score_accumulator with an event-level reference model.
module tb_score_accumulator;

  localparam int W = 16;
  localparam longint MAXV = (64'd1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   lines;
  logic [3:0]   level;
  logic [W-1:0] score;
  logic         done;
  logic         saturated;

  score_accumulator #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lines     (lines),
    .level     (level),
    .score     (score),
    .done      (done),
    .saturated (saturated)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: edges are numbered; an accepted event predicts the edge
  // after which done is visible, and the final score/saturation directly.
  int     edge_n      = 0;
  int     m_done_edge = -1;
  longint m_score     = 0;
  bit     m_sat       = 1'b0;

  function automatic longint pts(input int l);
    case (l)
      1:       return 40;
      2:       return 100;
      3:       return 300;
      4:       return 1200;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, updating the model first and checking after.
  task automatic tick();
    bit     busy_before;
    bit     busy_now;
    int     e;
    longint b;
    longint total;
    longint k;
    busy_before = (edge_n <= m_done_edge);
    e = edge_n + 1;
    if (reset || clear) begin
      m_score     = 0;
      m_sat       = 1'b0;
      m_done_edge = -1;
    end else if (in_valid && !busy_before) begin
      b = pts(int'(lines));
      if (m_sat || b == 0) begin
        m_done_edge = e;
      end else begin
        total = m_score + b * (longint'(level) + 1);
        if (total > MAXV) begin
          k           = (MAXV - m_score) / b + 1;
          m_score     = MAXV;
          m_sat       = 1'b1;
          m_done_edge = e + int'(k);
        end else begin
          m_score     = total;
          m_done_edge = e + int'(level) + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    edge_n   = e;
    busy_now = (e <= m_done_edge);
    chk("in_ready", 64'(in_ready), 64'(!busy_now));
    chk("done", 64'(done), 64'(e == m_done_edge));
    if (!busy_now || e == m_done_edge) begin
      chk("score", 64'(score), 64'(m_score));
      chk("saturated", 64'(saturated), 64'(m_sat));
    end
  endtask

  // Present one event from IDLE and return edges from accept until done is seen.
  task automatic run_event(input int l, input int lv, output int lat);
    int acc_e;
    lat      = -1;
    in_valid = 1'b1;
    lines    = 3'(l);
    level    = 4'(lv);
    tick();
    acc_e    = edge_n;
    in_valid = 1'b0;
    if (done) lat = 0;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      tick();
      if (done) lat = edge_n - acc_e;
    end
    if (lat < 0) chk("done_timeout", 64'(0), 64'(1));
    tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int lat;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; lines = '0; level = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_score", 64'(score), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'(1));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_sat", 64'(saturated), 64'(0));
    tick();

    // Single line at level 0: one add, done visible one edge after accept.
    run_event(1, 0, lat);
    chk("l1_lat", 64'(lat), 64'(1));
    chk("l1_score", 64'(score), 64'(40));

    // Tetris at level 9 from zero.
    do_clear();
    run_event(4, 9, lat);
    chk("t9_lat", 64'(lat), 64'(10));
    chk("t9_score", 64'(score), 64'(12000));
    chk("t9_sat", 64'(saturated), 64'(0));

    // Back-to-back tetrises until saturation.
    do_clear();
    for (int n = 0; n < 5; n++) run_event(4, 9, lat);
    chk("t5_score", 64'(score), 64'(60000));
    run_event(4, 9, lat);
    chk("t6_lat_early", 64'(lat), 64'(5));
    chk("t6_score", 64'(score), 64'(65535));
    chk("t6_sat", 64'(saturated), 64'(1));
    run_event(4, 9, lat);
    chk("t7_done_seen", 64'(lat >= 0), 64'(1));
    chk("t7_score", 64'(score), 64'(65535));

    // Zero-line event: immediate done, score unchanged.
    do_clear();
    run_event(1, 0, lat);
    run_event(0, 5, lat);
    chk("z_lat", 64'(lat), 64'(0));
    chk("z_score", 64'(score), 64'(40));

    // Clear on the third ADD cycle discards the event.
    do_clear();
    in_valid = 1'b1; lines = 3'd2; level = 4'd7;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_score", 64'(score), 64'(200));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_score", 64'(score), 64'(0));
    chk("clr_done", 64'(done), 64'(0));
    chk("clr_ready", 64'(in_ready), 64'(1));
    tick();

    // Clear and valid together in IDLE: the handshake is void.
    in_valid = 1'b1; lines = 3'd4; level = 4'd3; clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("cv_ready", 64'(in_ready), 64'(1));
    chk("cv_done", 64'(done), 64'(0));
    tick();
    chk("cv_score", 64'(score), 64'(0));

    // Reset mid-ADD aborts with no done pulse.
    in_valid = 1'b1; lines = 3'd3; level = 4'd15;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmid_done", 64'(done), 64'(0));
    chk("rmid_score", 64'(score), 64'(0));
    chk("rmid_ready", 64'(in_ready), 64'(1));
    run_event(1, 0, lat);
    chk("rmid_resume_lat", 64'(lat), 64'(1));

    // in_valid held high with random payloads and occasional clears.
    do_clear();
    in_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      lines = 3'($urandom_range(0, 7));
      level = 4'($urandom_range(0, 15));
      clear = ($urandom_range(0, 29) == 0);
      tick();
    end
    in_valid = 1'b0;
    clear    = 1'b0;
    for (int i = 0; i < 40 && edge_n <= m_done_edge; i++) tick();
    tick();
    chk("final_ready", 64'(in_ready), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
